// File: rtl/product_bcd_conv.sv
// product_bcd_conv: iterative binary-to-BCD converter (shift-add-3).
// Takes one IN_W-bit value per valid_in pulse and performs one shift per
// clock. The result appears on bcd_out together with a one-cycle done pulse.
module product_bcd_conv #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [IN_W-1:0]       bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Correct each nibble that is >= 5 by adding 3, then shift the scratch
  // left by one, taking in the next binary MSB. Each nibble add wraps
  // within 4 bits. When DIGITS is too small for IN_W, the top digit's
  // overflow is dropped silently.
  function automatic logic [BCD_W-1:0] add3_shift(input logic [BCD_W-1:0] scr,
                                                  input logic             msb);
    logic [BCD_W-1:0] adj;
    logic [3:0]       nib;
    adj = scr;
    for (int d = 0; d < DIGITS; d++) begin
      nib = scr[4*d +: 4];
      adj[4*d +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
    return (adj << 1) | BCD_W'(msb);
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IN_W-1:0]  r_bin;
  logic [BCD_W-1:0] r_scr;

  logic [BCD_W-1:0] w_scr_nxt;
  logic [IN_W-1:0]  w_bin_nxt;
  logic             w_last;

  assign w_scr_nxt = add3_shift(r_scr, r_bin[IN_W-1]);
  assign w_bin_nxt = {r_bin[IN_W-2:0], 1'b0};
  assign w_last    = (r_cnt == CNT_W'(IN_W - 1));

  // Control FSM and datapath. A new request is accepted only in IDLE or
  // DONE, so valid_in is ignored while a conversion is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_scr   <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (valid_in) begin
            r_bin   <= bin_in;
            r_scr   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_scr <= w_scr_nxt;
          r_bin <= w_bin_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // The final shifted scratch goes straight to the output on this edge.
            bcd_out <= w_scr_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_conv.sv
// Testbench for product_bcd_conv. The behavioural model tracks the latest
// accepted request by edge number and computes BCD with decimal arithmetic.
// The outputs are compared against this model on every falling edge.
module tb_product_bcd_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [7:0]  bin_in = '0;
  logic [11:0] bcd_out;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  product_bcd_conv #(.IN_W(8), .DIGITS(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    int h, t, o;
    h = (v / 100) % 10;
    t = (v / 10) % 10;
    o = v % 10;
    return 12'((h << 8) | (t << 4) | o);
  endfunction

  // Model state
  int          cyc      = 0;
  bit          have_acc = 1'b0;
  int          acc      = 0;
  logic [7:0]  acc_val  = '0;
  logic [11:0] exp_bcd  = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  int          n_acc    = 0;
  int          n_done   = 0;

  // Model: a request is taken unless edges acc+1..acc+8 belong to the
  // current conversion. The result lands 8 edges after acceptance.
  always @(posedge clk or posedge rst) begin
    cyc = cyc + 1;
    if (rst) begin
      have_acc = 1'b0;
      exp_bcd  = '0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (valid_in && (!have_acc || cyc > acc + 8)) begin
        have_acc = 1'b1;
        acc      = cyc;
        acc_val  = bin_in;
        n_acc    = n_acc + 1;
      end
      exp_done = have_acc && (cyc == acc + 8);
      exp_busy = have_acc && (cyc >= acc) && (cyc < acc + 8);
      if (exp_done) exp_bcd = to_bcd(int'(acc_val));
    end
  end

  // Compare process
  always @(negedge clk) begin
    checks = checks + 1;
    if (bcd_out !== exp_bcd || busy !== exp_busy || done !== exp_done) begin
      failures = failures + 1;
      $display("FAIL cycle_cmp cyc=%0d actual bcd=%h busy=%b done=%b required bcd=%h busy=%b done=%b",
               cyc, bcd_out, busy, done, exp_bcd, exp_busy, exp_done);
    end
    if (done === 1'b1) n_done = n_done + 1;
  end

  int acc_edge = 0;

  task automatic pulse(input logic [7:0] v);
    @(posedge clk); #1;
    valid_in = 1'b1;
    bin_in   = v;
    acc_edge = cyc + 1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_done(input string name, input logic [11:0] req);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
    end
    if (found) begin
      check({name, "_bcd"}, int'(bcd_out), int'(req));
      check({name, "_latency"}, cyc - acc_edge, 8);
    end else begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL %s_timeout actual=no_done required=done_within_20", name);
    end
  endtask

  int a0, d0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd", int'(bcd_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;

    // 1: basic conversion
    pulse(8'd225);
    wait_done("t1_225", 12'h225);

    // 2: boundary values
    pulse(8'd0);   wait_done("t2_0",   12'h000);
    pulse(8'd255); wait_done("t2_255", 12'h255);
    pulse(8'd9);   wait_done("t2_9",   12'h009);
    pulse(8'd100); wait_done("t2_100", 12'h100);

    // 3: valid_in while busy is ignored
    pulse(8'd49);
    repeat (2) @(posedge clk);
    #1;
    valid_in = 1'b1;
    bin_in   = 8'd7;
    @(posedge clk); #1;
    valid_in = 1'b0;
    wait_done("t3_49", 12'h049);
    repeat (10) @(negedge clk);
    check("t3_hold", int'(bcd_out), 12'h049);

    // 4: back-to-back start in the DONE cycle
    pulse(8'd81);
    wait_done("t4_81", 12'h081);
    valid_in = 1'b1;
    bin_in   = 8'd144;
    acc_edge = cyc + 1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    wait_done("t4_144", 12'h144);

    // 5: reset in the middle of a conversion
    pulse(8'd200);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_bcd", int'(bcd_out), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = n_done;
    repeat (12) @(negedge clk);
    check("t5_no_done", n_done - d0, 0);
    pulse(8'd36);
    wait_done("t5_36", 12'h036);

    // 6: full sweep
    a0 = n_acc;
    d0 = n_done;
    for (int v = 0; v < 256; v++) begin
      pulse(8'(v));
      wait_done("t6_sweep", to_bcd(v));
    end
    check("t6_accepts", n_acc - a0, 256);
    check("t6_dones", n_done - d0, 256);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
